// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg: shared types, byte-enable patterns and MEM/WB record for the RV32I memory stage
package rv32i_mem_pkg;
   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } mem_size_e;
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } memst_e;
   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;
   typedef struct packed {
      logic        reg_write;
      logic [4:0]  rd;
      logic [1:0]  result_src;
      logic [31:0] alu_result;
      logic [31:0] read_data;
      logic [31:0] pc_plus4;
      logic        misalign;
      logic        bus_err;
   } memwb_t;
   function automatic logic [3:0] store_be(input mem_size_e size, input logic [1:0] off);
      return (size == LB) ? BE_BYTE << off :
             (size == LH) ? BE_HALF << {off[1], 1'b0} :
             (size == LW) ? BE_WORD : BE_NONE;
   endfunction
endpackage

// File: rtl/rv32i_lsu_align.sv
// rv32i_lsu_align: combinational load extract, store lane/byte-enable generation and misalignment check
//   in : size (funct3), off (addr[1:0]), load, store, read_word (bus read data), store_data (rs2)
//   out: load_data (extended), lane_data (lane-replicated store data), be, misaligned
module rv32i_lsu_align
   import rv32i_mem_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  off,
   input  logic        load,
   input  logic        store,
   input  logic [31:0] read_word,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] lane_data,
   output logic [3:0]  be,
   output logic        misaligned
);
   mem_size_e  sz;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   assign sz       = mem_size_e'(size);
   assign byte_sel = read_word[{off, 3'b000} +: 8];
   assign half_sel = off[1] ? read_word[31:16] : read_word[15:0];
   always_comb begin
      load_data  = (sz == LB)  ? {{24{byte_sel[7]}}, byte_sel} :
                   (sz == LBU) ? {24'b0, byte_sel} :
                   (sz == LH)  ? {{16{half_sel[15]}}, half_sel} :
                   (sz == LHU) ? {16'b0, half_sel} :
                   (sz == LW)  ? read_word : '0;
      lane_data  = (sz == LB) ? {4{store_data[7:0]}} :
                   (sz == LH) ? {2{store_data[15:0]}} : store_data;
      be         = store ? store_be(sz, off) : load ? BE_WORD : BE_NONE;
      misaligned = (((sz == LH) | (sz == LHU)) & off[0]) | ((sz == LW) & (off != 2'b00));
   end
endmodule

// File: rtl/rv32i_memstage_hs.sv
// rv32i_memstage_hs: RV32I memory stage with req/ack data bus, stall generation, fault detection and MEM/WB register
//   in : clk, rst (async, active low), M-stage controls/data, dm_ack, dm_rdata
//   out: dm_req/dm_we/dm_addr/dm_be/dm_wdata bus, StallM to hazard unit, registered W-stage fields and fault flags
module rv32i_memstage_hs
   import rv32i_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ValidM,
   input  logic              RegWriteM,
   input  logic              MemReadM,
   input  logic              MemWriteM,
   input  logic [1:0]        ResultSrcM,
   input  logic [2:0]        MemSizeM,
   input  logic [31:0]       ALUResultM,
   input  logic [31:0]       WriteDataM,
   input  logic [31:0]       PCPlus4M,
   input  logic [4:0]        RdM,
   output logic              dm_req,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [3:0]        dm_be,
   output logic [31:0]       dm_wdata,
   input  logic              dm_ack,
   input  logic [31:0]       dm_rdata,
   output logic              StallM,
   output logic              RegWriteW,
   output logic [4:0]        RdW,
   output logic [1:0]        ResultSrcW,
   output logic [31:0]       ALUResultW,
   output logic [31:0]       ReadDataW,
   output logic [31:0]       PCPlus4W,
   output logic              MisalignW,
   output logic              BusErrW
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
   memst_e        state, state_next;
   logic [CW-1:0] count, count_next;
   logic          mem_op, misaligned, access, timeout, complete, bus_err;
   logic [31:0]   load_data;
   memwb_t        wb, wb_next;
   rv32i_lsu_align u_align (
      .size       (MemSizeM),
      .off        (ALUResultM[1:0]),
      .load       (MemReadM),
      .store      (MemWriteM),
      .read_word  (dm_rdata),
      .store_data (WriteDataM),
      .load_data  (load_data),
      .lane_data  (dm_wdata),
      .be         (dm_be),
      .misaligned (misaligned)
   );
   assign mem_op  = ValidM & (MemReadM | MemWriteM);
   assign access  = mem_op & !misaligned;
   assign dm_we   = MemWriteM;
   assign dm_addr = {ALUResultM[ADDR_W-1:2], 2'b00};
   // count equals the number of cycles already stalled for the current access
   assign timeout = (TIMEOUT_CYCLES != 0) & (state == WAIT) & (count == CW'(TIMEOUT_CYCLES));
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   always_comb begin
      state_next = (access & !dm_ack & ((state == IDLE) | !timeout)) ? WAIT : IDLE;
      count_next = (state_next == WAIT) ? ((state == IDLE) ? CW'(1) : count + 1'b1) : '0;
   end
   // gating with rst drops the request and the stall as soon as reset asserts
   always_comb begin
      complete = access & (dm_ack | timeout);
      bus_err  = access & timeout & !dm_ack;
      dm_req   = rst & access;
      StallM   = rst & access & !complete;
   end
   always_comb
      wb_next = '{
         reg_write:  RegWriteM & ValidM & !(mem_op & misaligned) & !bus_err,
         rd:         RdM,
         result_src: ResultSrcM,
         alu_result: ALUResultM,
         read_data:  (access & MemReadM & dm_ack) ? load_data : '0,
         pc_plus4:   PCPlus4M,
         misalign:   mem_op & misaligned,
         bus_err:    bus_err
      };
   always_ff @(posedge clk or negedge rst)
      if (!rst) wb <= '0;
      else      wb <= StallM ? '0 : wb_next;
   assign RegWriteW  = wb.reg_write;
   assign RdW        = wb.rd;
   assign ResultSrcW = wb.result_src;
   assign ALUResultW = wb.alu_result;
   assign ReadDataW  = wb.read_data;
   assign PCPlus4W   = wb.pc_plus4;
   assign MisalignW  = wb.misalign;
   assign BusErrW    = wb.bus_err;
endmodule

// File: tb/tb_rv32i_memstage_hs.sv
// tb_rv32i_memstage_hs: directed-vector bench with a cycle-level reference model of the memory stage
module tb_rv32i_memstage_hs;
   localparam int TO = 4;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ValidM, RegWriteM, MemReadM, MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  MemSizeM;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;
   logic        dm_req, dm_we, dm_ack;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_be;
   logic        StallM, RegWriteW, MisalignW, BusErrW;
   logic [4:0]  RdW;
   logic [1:0]  ResultSrcW;
   logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
   int checks = 0;
   int errors = 0;
   int stall_cnt = 0;
   int waited = 0;
   logic        e_rw = 1'b0, e_mis = 1'b0, e_berr = 1'b0;
   logic [4:0]  e_rd = '0;
   logic [1:0]  e_rs = '0;
   logic [31:0] e_alu = '0, e_rdata = '0, e_pc = '0;
   logic        m_op, m_mis, m_acc, m_to, m_stall;
   int          a, sz;
   logic [3:0]  x_be;
   logic [31:0] x_wd;

   rv32i_memstage_hs #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .ValidM(ValidM), .RegWriteM(RegWriteM), .MemReadM(MemReadM),
      .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .MemSizeM(MemSizeM), .ALUResultM(ALUResultM),
      .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM), .dm_req(dm_req), .dm_we(dm_we),
      .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .StallM(StallM), .RegWriteW(RegWriteW), .RdW(RdW), .ResultSrcW(ResultSrcW),
      .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
      .MisalignW(MisalignW), .BusErrW(BusErrW)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ext(input int s, input int off, input logic [31:0] w);
      int b, h;
      b = int'((w >> (8 * off)) & 32'hFF);
      h = int'((w >> (16 * (off / 2))) & 32'hFFFF);
      case (s)
         0: return (b >= 128) ? 32'(b - 256) : 32'(b);
         4: return 32'(b);
         1: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
         5: return 32'(h);
         2: return w;
         default: return 32'h0;
      endcase
   endfunction

   always @(negedge clk) if (StallM) stall_cnt++;

   always @(negedge clk or negedge rst) begin
      if (!rst) begin
         waited = 0;
         {e_rw, e_mis, e_berr, e_rd, e_rs, e_alu, e_rdata, e_pc} = '0;
      end else begin
         chk("RegWriteW", {31'b0, RegWriteW}, {31'b0, e_rw});
         chk("RdW", {27'b0, RdW}, {27'b0, e_rd});
         chk("ResultSrcW", {30'b0, ResultSrcW}, {30'b0, e_rs});
         chk("ALUResultW", ALUResultW, e_alu);
         chk("ReadDataW", ReadDataW, e_rdata);
         chk("PCPlus4W", PCPlus4W, e_pc);
         chk("MisalignW", {31'b0, MisalignW}, {31'b0, e_mis});
         chk("BusErrW", {31'b0, BusErrW}, {31'b0, e_berr});
         a = int'(ALUResultM[1:0]);
         sz = int'(MemSizeM);
         m_op = ValidM && (MemReadM || MemWriteM);
         m_mis = m_op && ((((sz == 1) || (sz == 5)) && (a % 2 != 0)) || ((sz == 2) && (a != 0)));
         m_acc = m_op && !m_mis;
         m_to = m_acc && !dm_ack && (TO != 0) && (waited == TO);
         m_stall = m_acc && !dm_ack && !m_to;
         chk("dm_req", {31'b0, dm_req}, {31'b0, m_acc});
         chk("StallM", {31'b0, StallM}, {31'b0, m_stall});
         if (m_acc) begin
            x_be = MemWriteM ? ((sz == 0) ? 4'(1 << a) : (sz == 1) ? 4'(3 << (a & 2)) : (sz == 2) ? 4'hF : 4'h0)
                             : 4'hF;
            x_wd = (sz == 0) ? {24'b0, WriteDataM[7:0]} * 32'h0101_0101 :
                   (sz == 1) ? {16'b0, WriteDataM[15:0]} * 32'h0001_0001 : WriteDataM;
            chk("dm_we", {31'b0, dm_we}, {31'b0, MemWriteM});
            chk("dm_addr", dm_addr, ALUResultM & 32'hFFFF_FFFC);
            chk("dm_be", {28'b0, dm_be}, {28'b0, x_be});
            if (MemWriteM) chk("dm_wdata", dm_wdata, x_wd);
         end
         if (m_stall) begin
            {e_rw, e_mis, e_berr, e_rd, e_rs, e_alu, e_rdata, e_pc} = '0;
            waited++;
         end else begin
            e_rw = RegWriteM && ValidM && !m_mis && !m_to;
            e_rd = RdM;
            e_rs = ResultSrcM;
            e_alu = ALUResultM;
            e_pc = PCPlus4M;
            e_mis = m_mis;
            e_berr = m_to;
            e_rdata = (m_acc && MemReadM && dm_ack) ? ext(sz, a, dm_rdata) : 32'h0;
            waited = 0;
         end
      end
   end

   task automatic drive(input logic v, rw, rd_en, wr_en, input logic [2:0] s, input logic [31:0] addr, wd);
      ValidM = v; RegWriteM = rw; MemReadM = rd_en; MemWriteM = wr_en;
      MemSizeM = s; ALUResultM = addr; WriteDataM = wd;
      RdM = addr[4:0] ^ 5'd7; ResultSrcM = {1'b0, rd_en}; PCPlus4M = addr + 32'h1000;
   endtask

   // ackd: stalled cycles before the ack (0 = same cycle), -1 = memory never answers
   task automatic op(input logic v, rw, rd_en, wr_en, input logic [2:0] s, input logic [31:0] addr, wd, rdata,
                     input int ackd);
      int n;
      bit acc;
      drive(v, rw, rd_en, wr_en, s, addr, wd);
      acc = v && (rd_en || wr_en) && !((((s == 3'd1) || (s == 3'd5)) && addr[0]) || ((s == 3'd2) && (addr[1:0] != 2'b00)));
      n = !acc ? 1 : (ackd >= 0 && ackd <= TO) ? ackd + 1 : TO + 1;
      for (int i = 0; i < n; i++) begin
         dm_ack = acc && (i == ackd);
         dm_rdata = (i == ackd) ? rdata : 32'h5A5A_5A5A;
         @(posedge clk); #1;
      end
      dm_ack = 1'b0;
      drive(0, 0, 0, 0, 3'd0, 32'h0, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s0;
      dm_ack = 1'b0;
      dm_rdata = 32'h0;
      drive(0, 0, 0, 0, 3'd0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset RegWriteW", {31'b0, RegWriteW}, 32'h0);
      chk("reset PCPlus4W", PCPlus4W, 32'h0);
      chk("reset dm_req", {31'b0, dm_req}, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      s0 = stall_cnt;
      op(1, 1, 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0);
      chk("t1 stalls", 32'(stall_cnt - s0), 32'd0);
      chk("t1 ReadDataW", ReadDataW, 32'hFFFF_FF80);
      chk("t1 RegWriteW", {31'b0, RegWriteW}, 32'h1);
      s0 = stall_cnt;
      op(1, 1, 1, 0, 3'b101, 32'h202, 32'h0, 32'hBEEF_0000, 3);
      chk("t2 stalls", 32'(stall_cnt - s0), 32'd3);
      chk("t2 ReadDataW", ReadDataW, 32'h0000_BEEF);
      chk("t2 RegWriteW", {31'b0, RegWriteW}, 32'h1);
      drive(1, 0, 0, 1, 3'b000, 32'h07, 32'h1234_56AB);
      dm_ack = 1'b1;
      #2;
      chk("t3 dm_be", {28'b0, dm_be}, 32'h8);
      chk("t3 dm_wdata", dm_wdata, 32'hABAB_ABAB);
      chk("t3 dm_addr", dm_addr, 32'h4);
      @(posedge clk); #1;
      dm_ack = 1'b0;
      drive(0, 0, 0, 0, 3'd0, 32'h0, 32'h0);
      chk("t3 RegWriteW", {31'b0, RegWriteW}, 32'h0);
      drive(1, 1, 1, 0, 3'b010, 32'h0A, 32'h0);
      #2;
      chk("t4 dm_req", {31'b0, dm_req}, 32'h0);
      chk("t4 StallM", {31'b0, StallM}, 32'h0);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 3'd0, 32'h0, 32'h0);
      chk("t4 MisalignW", {31'b0, MisalignW}, 32'h1);
      chk("t4 RegWriteW", {31'b0, RegWriteW}, 32'h0);
      s0 = stall_cnt;
      op(1, 1, 1, 0, 3'b010, 32'h10, 32'h0, 32'h0, -1);
      chk("t5 stalls", 32'(stall_cnt - s0), 32'd4);
      chk("t5 BusErrW", {31'b0, BusErrW}, 32'h1);
      chk("t5 RegWriteW", {31'b0, RegWriteW}, 32'h0);
      s0 = stall_cnt;
      op(1, 1, 1, 0, 3'b010, 32'h14, 32'h0, 32'h1357_9BDF, 0);
      chk("t5 recover stalls", 32'(stall_cnt - s0), 32'd0);
      chk("t5 recover ReadDataW", ReadDataW, 32'h1357_9BDF);
      drive(1, 1, 1, 0, 3'b010, 32'h20, 32'h0);
      dm_ack = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("t6 StallM before reset", {31'b0, StallM}, 32'h1);
      rst = 1'b0;
      #1;
      chk("t6 dm_req", {31'b0, dm_req}, 32'h0);
      chk("t6 StallM", {31'b0, StallM}, 32'h0);
      chk("t6 RegWriteW", {31'b0, RegWriteW}, 32'h0);
      chk("t6 PCPlus4W", PCPlus4W, 32'h0);
      drive(0, 0, 0, 0, 3'd0, 32'h0, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      s0 = stall_cnt;
      op(1, 1, 1, 0, 3'b010, 32'h24, 32'h0, 32'hCAFE_F00D, 0);
      chk("t6 restart stalls", 32'(stall_cnt - s0), 32'd0);
      chk("t6 restart ReadDataW", ReadDataW, 32'hCAFE_F00D);
      chk("t6 restart RegWriteW", {31'b0, RegWriteW}, 32'h1);
      op(1, 0, 0, 1, 3'b001, 32'h12, 32'h0000_9876, 32'h0, 1);
      op(1, 1, 1, 0, 3'b001, 32'h06, 32'h0, 32'h8001_0000, 0);
      chk("lh ReadDataW", ReadDataW, 32'hFFFF_8001);
      op(1, 1, 1, 0, 3'b100, 32'h01, 32'h0, 32'h0000_F000, 2);
      chk("lbu ReadDataW", ReadDataW, 32'h0000_00F0);
      op(1, 0, 0, 1, 3'b010, 32'h40, 32'hDEAD_0001, 32'h0, 2);
      op(1, 1, 1, 0, 3'b010, 32'h44, 32'h0, 32'h0BAD_F00D, TO);
      chk("ack at limit BusErrW", {31'b0, BusErrW}, 32'h0);
      chk("ack at limit ReadDataW", ReadDataW, 32'h0BAD_F00D);
      op(1, 0, 0, 1, 3'b001, 32'h33, 32'h1111_2222, 32'h0, 0);
      op(1, 1, 0, 0, 3'b001, 32'h55, 32'h0, 32'h0, 0);
      chk("alu RegWriteW", {31'b0, RegWriteW}, 32'h1);
      op(0, 1, 1, 0, 3'b010, 32'h60, 32'h0, 32'h0, 0);
      op(1, 0, 0, 1, 3'b110, 32'h68, 32'h7777_8888, 32'h0, 0);
      repeat (2) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rv32i_memstage_hs.md
Name: rv32i_memstage_hs

Overview:
Memory-access stage of the RV32I pipeline with a variable-latency data-memory handshake. The previous stage assumed a zero-wait memory and a fixed load-extract path. This block adds:
- a req/ack bus with stall generation to the hazard unit,
- store byte-enable and lane generation,
- misalignment and bus-timeout detection.
It sits between the EX/MEM register and the writeback stage, and contains the MEM/WB pipeline register.

Parameters:
- TIMEOUT_CYCLES, 16: wait cycles before bus error is declared; 0 disables the timeout.
- ADDR_W, 32: width of dm_addr; the low ADDR_W bits of ALUResultM are used.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- ValidM  in  1  instruction in M is valid (not a bubble)
- RegWriteM  in  1  register write enable
- MemReadM  in  1  instruction is a load
- MemWriteM  in  1  instruction is a store
- ResultSrcM  in  2  writeback mux select
- MemSizeM  in  3  funct3 of the load/store
- ALUResultM  in  32  effective address / ALU result
- WriteDataM  in  32  store data (rs2)
- PCPlus4M  in  32  PC+4
- RdM  in  5  destination register
- dm_req  out  1  bus request
- dm_we  out  1  bus write
- dm_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- dm_be  out  4  byte enables
- dm_wdata  out  32  lane-aligned store data
- dm_ack  in  1  access complete; dm_rdata valid on a load ack
- dm_rdata  in  32  read word
- StallM  out  1  to hazard unit; freezes F/D/E and the EX/MEM register
- RegWriteW  out  1  registered
- RdW  out  5  registered
- ResultSrcW  out  2  registered
- ALUResultW  out  32  registered
- ReadDataW  out  32  registered
- PCPlus4W  out  32  registered
- MisalignW  out  1  registered fault flag
- BusErrW  out  1  registered fault flag

Behaviour:

Reset (rst=0, asynchronous) forces:
- all W outputs to 0;
- FSM to IDLE and wait counter to 0;
- combinationally, dm_req=0 and StallM=0.

Access qualification:
- mem_op = ValidM & (MemReadM | MemWriteM).
- misaligned when:
  - size is H/HU and addr[0]=1, or
  - size is W and addr[1:0]≠0.
- access = mem_op & !misaligned.

FSM states: IDLE and WAIT.
- dm_req = access & (state IDLE or WAIT); dm_we = MemWriteM.
- IDLE:
  - access & dm_ack → complete in the same cycle, no stall.
  - access & !dm_ack → go to WAIT; count = 1.
- WAIT:
  - dm_ack → complete; go to IDLE.
  - otherwise, if TIMEOUT_CYCLES≠0 and count == TIMEOUT_CYCLES → complete with BusErr; go to IDLE.
  - otherwise count increments.
- StallM = access & !complete.
- Upstream holds all M inputs stable while StallM=1.
- An ack arriving after a timeout is ignored; the memory must not issue it.

MEM/WB register, on each clock edge:
- StallM=1: load a bubble (RegWriteW=0, MisalignW=0, BusErrW=0; other fields don't-care, driven 0).
- StallM=0: capture the M fields.
  - RegWriteW = RegWriteM & ValidM & !misaligned & !buserr.
  - MisalignW = mem_op & misaligned; no bus request is issued.
  - BusErrW = timeout completion.

Load extract (from dm_rdata with addr[1:0], combinational before the register):
- 000 LB: sign-extend the selected byte.
- 100 LBU: zero-extend the selected byte.
- 001 LH: sign-extend the selected half (addr[1]).
- 101 LHU: zero-extend the selected half (addr[1]).
- 010 LW: full word.
- Other encodings: ReadData = 0.
- ReadDataW = 0 for non-loads.

Store lanes:
- SB: be = 4'b0001 << addr[1:0]; wdata = byte replicated ×4.
- SH: be = 4'b0011 << {addr[1],1'b0}; wdata = half replicated ×2.
- SW: be = 4'b1111.
- Reserved size or load: be = 4'b0000 on stores, 4'b1111 on loads.

Reset mid-WAIT: dm_req drops immediately; the instruction is lost, and the system restarts from reset.

Decomposition:
- Package rv32i_mem_pkg holds:
  - typedef mem_size_e (LB=3'b000, LH=001, LW=010, LBU=100, LHU=101);
  - typedef memst_e {IDLE, WAIT};
  - function/constants for be patterns.
- One sub-module: rv32i_lsu_align, combinational. It performs load extract, store lane/be generation and the misalignment check.
- The FSM, timeout counter and MEM/WB register stay at top level.

Test Plan:
1. LB, addr 0x103, dm_rdata 0x80FF_1234, ack in the same cycle → StallM never 1; next edge ReadDataW=0xFFFF_FF80, RegWriteW=1.
2. LHU, addr 0x202, ack after 3 wait cycles, rdata 0xBEEF_0000 → StallM=1 for 3 cycles with bubble W outputs; on the ack edge ReadDataW=0x0000_BEEF.
3. SB, addr 0x07, WriteDataM=0x1234_56AB → dm_be=4'b1000, dm_wdata=0xABAB_ABAB, dm_addr=0x04; RegWriteW=0.
4. LW, addr 0x0A → dm_req stays 0, StallM=0; next edge MisalignW=1, RegWriteW=0.
5. TIMEOUT_CYCLES=4, LW with no ack → StallM high for exactly 4 cycles, then BusErrW=1, RegWriteW=0; FSM returns to IDLE.
6. Assert rst=0 during WAIT → dm_req and StallM drop immediately (asynchronously); all W outputs read 0; after release, a new LW with immediate ack completes normally.
